instr_fetch_unit: RTL

//  Parametrised successor to the single-instruction fetch stage: decouples the core from instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_if.sv | 32 +++
 rtl/instr_fetch_unit_fetch_queue.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional performance counters are enabled with FETCH_PERF_CNT_EN.
package instr_fetch_unit_pkg;

    localparam int FETCH_XLEN  = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        instr_t                instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response, decode and redirect channels of the fetch unit.
// master is the fetch unit side; slave is the memory/core side.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    import instr_fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    instr_t          imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    instr_t          instr;
    logic [XLEN-1:0] instr_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fetch_unit_fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests and compute next pointer/count values.
    always_comb begin
        do_push_s = push_i && !flush_i && (count_q != FULL_CNT);
        do_pop_s  = pop_i && !flush_i && (count_q != (AW+1)'(0));
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding request FSM, redirect handling
// and a prefetch queue toward decode. Define FETCH_PERF_CNT_EN for perf counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  fetch_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_flushed
`endif
);

    localparam int              CW            = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_DEPTH     = CW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        instr_t          instr;
    } entry_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            started_q;

    logic            req_valid_s;
    logic            req_fire_s;
    logic            instr_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            flush_s;
    entry_t          push_data_s;
    entry_t          head_s;
    logic [CW-1:0]   count_s;

    // Request and decode handshake decoding, all from registered state.
    always_comb begin
        req_valid_s   = started_q && (state_q == FS_REQ) && (count_s < CNT_DEPTH);
        req_fire_s    = req_valid_s && fetch_if.imem_req_ready;
        instr_valid_s = (count_s != CW'(0));
        pop_s         = instr_valid_s && fetch_if.instr_ready && !fetch_if.redirect_valid;
        flush_s       = fetch_if.redirect_valid;
        push_data_s   = '{pc: addr_q, instr: fetch_if.imem_rsp_data};
    end

    // Next-state logic; a redirect overrides any push/pop in the same cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        push_s  = 1'b0;
        if (fetch_if.redirect_valid) begin
            pc_d = fetch_if.redirect_pc & PC_ALIGN_MASK;
            case (state_q)
                FS_REQ:   state_d = req_fire_s ? FS_FLUSH : FS_REQ;
                FS_WAIT:  state_d = fetch_if.imem_rsp_valid ? FS_REQ : FS_FLUSH;
                FS_FLUSH: state_d = fetch_if.imem_rsp_valid ? FS_REQ : FS_FLUSH;
                default:  state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (req_fire_s) begin
                        state_d = FS_WAIT;
                        pc_d    = pc_q + PC_STEP;
                        addr_d  = pc_q;
                    end else begin
                        state_d = FS_REQ;
                    end
                end
                FS_WAIT: begin
                    if (fetch_if.imem_rsp_valid) begin
                        push_s  = 1'b1;
                        state_d = FS_REQ;
                    end else begin
                        state_d = FS_WAIT;
                    end
                end
                // The response to a request made before the redirect is dropped here.
                FS_FLUSH: begin
                    if (fetch_if.imem_rsp_valid) begin
                        state_d = FS_REQ;
                    end else begin
                        state_d = FS_FLUSH;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end
    end

    // FSM, PC and outstanding-address registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FS_REQ;
            pc_q      <= RESET_PC;
            addr_q    <= {XLEN{1'b0}};
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            started_q <= 1'b1;
        end
    end

    instr_fetch_unit_fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fetch_queue (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (flush_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign fetch_if.imem_req_valid = req_valid_s;
    assign fetch_if.imem_req_addr  = req_valid_s ? pc_q : {XLEN{1'b0}};
    assign fetch_if.instr_valid    = instr_valid_s;
    assign fetch_if.instr          = instr_valid_s ? head_s.instr : 32'h0000_0000;
    assign fetch_if.instr_pc       = instr_valid_s ? head_s.pc : {XLEN{1'b0}};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Saturating counts of pushed responses and taken redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 32'h0000_0000;
            perf_flushed_q <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                perf_fetched_q <= sat_inc32(perf_fetched_q);
            end
            if (fetch_if.redirect_valid) begin
                perf_flushed_q <= sat_inc32(perf_flushed_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
